uart_ctrl: RTL and testbench
============================

# uart_ctrl

Byte-level UART controller sitting directly below the memory-mapped peripheral block. It serialises the byte presented on `tx_data` when `tx_en` rises, deserialises bytes arriving on `uart_rx`, and exposes `tx_status`, `rx_eff`, `rx_data` and `rx_read` to match the peripheral's UART_CON / UART_TXD / UART_RXD registers. Framing is 8-N-1, or 8-E-1 when parity is compiled in, with a shared 16x-oversampling baud generator.

## Interface
- `DIVISOR`, default 27: clk cycles per oversample tick. One bit time = 16 ticks = 16·DIVISOR clk. Legal range 1..65535.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `tx_data` in 8: byte to send. Sampled on the accepting edge only.
- `tx_en` in 1: level from the peripheral TX_EN register. A 0→1 transition requests a send.
- `tx_status` out 1: 1 = transmitter idle and ready; 0 = frame in progress.
- `rx_data` out 8: last good received byte.
- `rx_eff` out 1: 1 = `rx_data` holds an unread byte.
- `rx_read` in 1: single-cycle pulse from the peripheral on a UART_RXD read. Clears `rx_eff`.
- `uart_tx` out 1: serial line out, idle high.
- `uart_rx` in 1: serial line in, asynchronous, idle high.

## Operation
- **Baud generator**
  - 16-bit counter counts 0..DIVISOR-1, then wraps.
  - `tick` pulses for one clk on the wrap.
  - The counter is free-running; TX and RX share it.
- **TX FSM** (states IDLE, START, DATA, PARITY, STOP)
  - `tx_en` is registered once; a rising edge is `prev==0 && cur==1`.
  - IDLE→START on a rising edge while in IDLE: latch `tx_data`, clear bit index, drive `tx_status`=0.
  - A rising edge while not in IDLE is ignored and is not queued.
  - Each state lasts 16 ticks.
    - START: `uart_tx`=0.
    - DATA: bits 0..7, LSB first.
    - PARITY: only with the macro; even parity = XOR of the data bits.
    - STOP: `uart_tx`=1.
  - After STOP go to IDLE and set `tx_status`=1.
  - Holding `tx_en` high does not resend; software must write 0 and then 1.
- **RX path**
  - `uart_rx` passes through a 2-FF synchroniser, initialised to 1.
- **RX FSM** (states IDLE, START, DATA, PARITY, STOP)
  - IDLE→START when the synchronised line is 0 on a tick.
  - START: after 8 ticks re-sample.
    - If 1: false start, return to IDLE.
    - If 0: go to DATA.
  - DATA: sample every 16 ticks (mid-bit) into a shift register, LSB first.
  - PARITY: only with the macro.
  - STOP: sample at mid-bit.
    - 1 (and parity ok): `rx_data`←shift register, `rx_eff`←1.
    - 0, or parity bad: discard the byte; `rx_data`/`rx_eff` unchanged.
  - Return to IDLE right after the stop sample. The second half of the stop bit overlaps IDLE hunting.
- **Overrun**: a new good byte overwrites `rx_data`; `rx_eff` stays 1.
- **Simultaneous `rx_read` and new-byte commit**: the commit wins, so `rx_eff`=1 and `rx_data` = new byte.
- **`rx_read` while `rx_eff`=0**: no effect.
- **Reset mid-frame**: both FSMs go to IDLE immediately, the frame is abandoned, and `uart_tx` returns high asynchronously.

## Timing
- **Reset values**: `uart_tx`=1, `tx_status`=1, `rx_eff`=0, `rx_data`=8'h00. FSMs IDLE, baud counter 0, `tx_en` history 0.
- **TX**
  - `tx_status` falls 2 clk after `tx_en` rises: register, then FSM.
  - `uart_tx` falls on the first tick after acceptance, so the start delay is at most DIVISOR clk.
  - Frame is 10 bit times (11 with parity) = 160·DIVISOR clk (176·DIVISOR with parity).
  - `tx_status` rises on the clk following the last STOP tick.
- **RX**
  - `rx_eff` rises 1 clk after the stop-bit mid sample. That is about 9.5 bit times after the start edge (10.5 with parity), plus 2 clk of synchroniser delay and ±1 tick of detection jitter.
  - `rx_eff` clears on the clk after the `rx_read` pulse.
- All outputs are registered. No combinational input→output paths.

## Configuration
- `UART_PARITY_EN`
  - Defined: both TX and RX insert/expect an even-parity bit between bit 7 and the stop bit. RX discards bytes with bad parity.
  - Undefined: PARITY states and parity logic are not compiled; framing is 8-N-1.

## Test plan
All scenarios use DIVISOR=4, so one bit = 64 clk.
- **Reset values**: assert `reset` low mid-TX-frame → `uart_tx`=1, `tx_status`=1, `rx_eff`=0 immediately. After release, no spurious frame.
- **TX byte 8'hA5**: pulse `tx_en` 0→1 with `tx_data`=8'hA5.
  - `uart_tx` shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, at 64 clk/bit.
  - `tx_status` is 0 for 640 clk, then 1.
  - A second rising edge mid-frame is ignored.
- **RX byte 8'h3C**: drive `uart_rx` with an 8'h3C frame at 64 clk/bit.
  - `rx_eff`=1 and `rx_data`=8'h3C about 608 clk after the start edge.
  - An `rx_read` pulse clears `rx_eff` on the next clk.
- **False start / framing error**
  - A 20-clk low glitch on `uart_rx` → no byte.
  - A frame with stop bit=0 → `rx_eff` stays 0 and `rx_data` is unchanged.
- **Overrun and collision**: receive 8'h11 and 8'h22 without reading → `rx_data`=8'h22, `rx_eff`=1. Assert `rx_read` on the commit clk of 8'h33 → `rx_eff`=1, `rx_data`=8'h33.
- **`UART_PARITY_EN`**
  - TX 8'h07 → parity bit 1, frame 704 clk.
  - RX 8'h07 with parity bit 0 → discarded.
  - RX 8'h07 with parity bit 1 → `rx_data`=8'h07.

Source files
------------

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: peripheral-side byte port plus serial lines of uart_ctrl.
// master = peripheral/line driver, slave = the controller.
interface uart_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic [7:0] rx_data;
  logic       rx_eff;
  logic       rx_read;
  logic       uart_tx;
  logic       uart_rx;

  modport master (
    output tx_data, tx_en, rx_read, uart_rx,
    input  tx_status, rx_data, rx_eff, uart_tx
  );

  modport slave (
    input  tx_data, tx_en, rx_read, uart_rx,
    output tx_status, rx_data, rx_eff, uart_tx
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: 8-N-1 byte UART with shared 16x baud tick.
// Define UART_PARITY_EN for 8-E-1 framing on both TX and RX.
module uart_ctrl #(
  parameter int unsigned DIVISOR = 27
) (
  input logic        clk,
  input logic        reset,
  uart_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } st_t;

  logic [15:0] bcnt;
  logic        tick;

  assign tick = (bcnt == 16'(DIVISOR - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    bcnt <= '0;
    else if (tick) bcnt <= '0;
    else           bcnt <= bcnt + 16'd1;
  end

  logic       en_q, en_qq, rise;
  st_t        tx_st, tx_nx;
  logic [3:0] tx_tc, tx_tc_n;
  logic [2:0] tx_bi, tx_bi_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic       tx_ln, tx_ln_n;
  logic       tx_rdy, tx_rdy_n;

  assign rise = en_q & ~en_qq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      en_qq  <= 1'b0;
      tx_st  <= IDLE;
      tx_tc  <= '0;
      tx_bi  <= '0;
      tx_sh  <= '0;
      tx_ln  <= 1'b1;
      tx_rdy <= 1'b1;
    end else begin
      en_q   <= bus.tx_en;
      en_qq  <= en_q;
      tx_st  <= tx_nx;
      tx_tc  <= tx_tc_n;
      tx_bi  <= tx_bi_n;
      tx_sh  <= tx_sh_n;
      tx_ln  <= tx_ln_n;
      tx_rdy <= tx_rdy_n;
    end
  end

  // The line register is refreshed on every tick, so it trails
  // the state by one tick and each level spans exactly 16 ticks.
  always_comb begin
    tx_nx    = tx_st;
    tx_tc_n  = tx_tc;
    tx_bi_n  = tx_bi;
    tx_sh_n  = tx_sh;
    tx_ln_n  = tx_ln;
    tx_rdy_n = tx_rdy;
    if (tx_st == IDLE) begin
      tx_ln_n = 1'b1;
      if (rise) begin
        tx_nx    = START;
        tx_sh_n  = bus.tx_data;
        tx_bi_n  = '0;
        tx_tc_n  = '0;
        tx_rdy_n = 1'b0;
      end
    end else if (tick) begin
      tx_tc_n = tx_tc + 4'd1;
      case (tx_st)
        START:   tx_ln_n = 1'b0;
        DATA:    tx_ln_n = tx_sh[tx_bi];
`ifdef UART_PARITY_EN
        PARITY:  tx_ln_n = ^tx_sh;
`endif
        default: tx_ln_n = 1'b1;
      endcase
      if (tx_tc == 4'd15) begin
        case (tx_st)
          START: tx_nx = DATA;
          DATA: begin
            if (tx_bi == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_nx = PARITY;
`else
              tx_nx = STOP;
`endif
            end else begin
              tx_bi_n = tx_bi + 3'd1;
            end
          end
`ifdef UART_PARITY_EN
          PARITY: tx_nx = STOP;
`endif
          default: begin
            tx_nx    = IDLE;
            tx_rdy_n = 1'b1;
          end
        endcase
      end
    end
  end

  logic       s1, s2;
  st_t        rx_st, rx_nx;
  logic [3:0] rx_tc, rx_tc_n;
  logic [2:0] rx_bi, rx_bi_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic [7:0] rdata;
  logic       reff, commit, par_ok;

`ifdef UART_PARITY_EN
  logic pb, pb_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pb <= 1'b0;
    else        pb <= pb_n;
  end
  assign par_ok = ~(^{rx_sh, pb});
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      rx_st <= IDLE;
      rx_tc <= '0;
      rx_bi <= '0;
      rx_sh <= '0;
      rdata <= '0;
      reff  <= 1'b0;
    end else begin
      s1    <= bus.uart_rx;
      s2    <= s1;
      rx_st <= rx_nx;
      rx_tc <= rx_tc_n;
      rx_bi <= rx_bi_n;
      rx_sh <= rx_sh_n;
      if (commit) begin
        rdata <= rx_sh;
        reff  <= 1'b1;
      end else if (bus.rx_read) begin
        reff  <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_nx   = rx_st;
    rx_tc_n = rx_tc;
    rx_bi_n = rx_bi;
    rx_sh_n = rx_sh;
    commit  = 1'b0;
`ifdef UART_PARITY_EN
    pb_n    = pb;
`endif
    if (tick) begin
      rx_tc_n = rx_tc + 4'd1;
      case (rx_st)
        IDLE: begin
          rx_tc_n = '0;
          if (!s2) rx_nx = START;
        end
        START: begin
          if (rx_tc == 4'd7) begin
            rx_tc_n = '0;
            rx_bi_n = '0;
            rx_nx   = s2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (rx_tc == 4'd15) begin
            rx_sh_n = {s2, rx_sh[7:1]};
            if (rx_bi == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_nx = PARITY;
`else
              rx_nx = STOP;
`endif
            end else begin
              rx_bi_n = rx_bi + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (rx_tc == 4'd15) begin
            pb_n  = s2;
            rx_nx = STOP;
          end
        end
`endif
        default: begin
          if (rx_tc == 4'd15) begin
            rx_nx  = IDLE;
            commit = s2 & par_ok;
          end
        end
      endcase
    end
  end

  assign bus.uart_tx   = tx_ln;
  assign bus.tx_status = tx_rdy;
  assign bus.rx_data   = rdata;
  assign bus.rx_eff    = reff;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed checks of uart_ctrl at DIVISOR=4.
// Tick phase is learned from the TX start edge and reused for RX.
module tb_uart_ctrl;

  localparam int DIV = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int COMMIT = 3 + DIV * (8 + 16 * (9 + P));

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_ctrl_if bus ();

  uart_ctrl #(.DIVISOR(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p0, f, e0, phase;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] o,
                      input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tx_run(input logic [7:0] b);
    logic ex;
    int n;
    bus.tx_data = b;
    bus.tx_en = 1'b1;
    e0 = cyc;
    step(1);
    chk1("tx_st_hold", bus.tx_status, 1'b1);
    step(1);
    chk1("tx_st_fall", bus.tx_status, 1'b0);
    n = 0;
    while (bus.uart_tx !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
    chk1("tx_start_seen", bus.uart_tx, 1'b0);
    f = cyc;
    phase = f % DIV;
    chk1("tx_start_dly",
         logic'((f - e0 - 2) >= 1 && (f - e0 - 2) <= DIV), 1'b1);
    for (int i = 0; i <= 9 + P; i++) begin
      to(f + 32 + 64 * i);
      if (i == 0)           ex = 1'b0;
      else if (i <= 8)      ex = b[i-1];
      else if (i == 9 + P)  ex = 1'b1;
      else                  ex = ^b;
      chk1($sformatf("tx_bit%0d", i), bus.uart_tx, ex);
      if (i == 3) begin
        step(2);
        bus.tx_en = 1'b0;
        step(2);
        bus.tx_en = 1'b1;
      end
    end
    to(f + DIV * (16 * (10 + P) - 1) - 1);
    chk1("tx_st_busy", bus.tx_status, 1'b0);
    to(f + DIV * (16 * (10 + P) - 1) + 1);
    chk1("tx_st_rise", bus.tx_status, 1'b1);
    to(f + 64 * (10 + P) + 40);
    chk1("tx_noqueue_ln", bus.uart_tx, 1'b1);
    chk1("tx_noqueue_st", bus.tx_status, 1'b1);
    bus.tx_en = 1'b0;
    step(4);
  endtask

  task automatic rx_head(input logic [7:0] b, input logic stopv,
                         input logic pv);
    while ((cyc + 3) % DIV != phase) step(1);
    p0 = cyc;
    bus.uart_rx = 1'b0;
    step(64);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      step(64);
    end
    if (P == 1) begin
      bus.uart_rx = pv;
      step(64);
    end
    bus.uart_rx = stopv;
  endtask

  task automatic rx_tail();
    to(p0 + 64 * (10 + P));
    bus.uart_rx = 1'b1;
    step(40);
  endtask

  task automatic rd_pulse();
    bus.rx_read = 1'b1;
    step(1);
    bus.rx_read = 1'b0;
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_en   = 1'b0;
    bus.rx_read = 1'b0;
    bus.uart_rx = 1'b1;
    phase = 0;
    step(3);
    chk1("rst_tx", bus.uart_tx, 1'b1);
    chk1("rst_st", bus.tx_status, 1'b1);
    chk1("rst_eff", bus.rx_eff, 1'b0);
    chk8("rst_data", bus.rx_data, 8'h00);
    reset = 1'b1;
    step(5);

    bus.tx_data = 8'h00;
    bus.tx_en = 1'b1;
    step(100);
    chk1("mid_tx", bus.uart_tx, 1'b0);
    chk1("mid_st", bus.tx_status, 1'b0);
    reset = 1'b0;
    #1;
    chk1("arst_tx", bus.uart_tx, 1'b1);
    chk1("arst_st", bus.tx_status, 1'b1);
    chk1("arst_eff", bus.rx_eff, 1'b0);
    bus.tx_en = 1'b0;
    step(3);
    reset = 1'b1;
    step(200);
    chk1("nospur_tx", bus.uart_tx, 1'b1);
    chk1("nospur_st", bus.tx_status, 1'b1);

    tx_run(8'hA5);

    rx_head(8'h3C, 1'b1, ^8'h3C);
    to(p0 + COMMIT - 11);
    chk1("rx_early", bus.rx_eff, 1'b0);
    to(p0 + COMMIT + 9);
    chk1("rx_eff", bus.rx_eff, 1'b1);
    chk8("rx_data", bus.rx_data, 8'h3C);
    rd_pulse();
    chk1("rx_read_clr", bus.rx_eff, 1'b0);
    rd_pulse();
    chk1("rx_read_idle", bus.rx_eff, 1'b0);
    chk8("rx_read_keep", bus.rx_data, 8'h3C);
    rx_tail();

    bus.uart_rx = 1'b0;
    step(20);
    bus.uart_rx = 1'b1;
    step(700);
    chk1("glitch_eff", bus.rx_eff, 1'b0);
    chk8("glitch_data", bus.rx_data, 8'h3C);

    rx_head(8'h5A, 1'b0, ^8'h5A);
    rx_tail();
    step(100);
    chk1("frm_eff", bus.rx_eff, 1'b0);
    chk8("frm_data", bus.rx_data, 8'h3C);

    rx_head(8'h11, 1'b1, ^8'h11);
    rx_tail();
    rx_head(8'h22, 1'b1, ^8'h22);
    rx_tail();
    chk1("ovr_eff", bus.rx_eff, 1'b1);
    chk8("ovr_data", bus.rx_data, 8'h22);

    rx_head(8'h33, 1'b1, ^8'h33);
    to(p0 + COMMIT - 1);
    chk8("col_pre", bus.rx_data, 8'h22);
    rd_pulse();
    chk1("col_eff", bus.rx_eff, 1'b1);
    chk8("col_data", bus.rx_data, 8'h33);
    rx_tail();

`ifdef UART_PARITY_EN
    tx_run(8'h07);
    rd_pulse();
    rx_head(8'h07, 1'b1, 1'b0);
    rx_tail();
    chk1("par_bad_eff", bus.rx_eff, 1'b0);
    chk8("par_bad_data", bus.rx_data, 8'h33);
    rx_head(8'h07, 1'b1, 1'b1);
    rx_tail();
    chk1("par_ok_eff", bus.rx_eff, 1'b1);
    chk8("par_ok_data", bus.rx_data, 8'h07);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
